// File: rtl/openhw_align_rshift.sv
// Multi-cycle right shifter that ORs every bit shifted out into a sticky flag.
// Optional RSHIFT_FASTZERO_EN: amounts >= WIDTH complete without iterating.
module openhw_align_rshift #(
  parameter int WIDTH  = 64,
  parameter int SHIFTW = 7,
  parameter int STEP   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [SHIFTW-1:0] ShiftAmt,
  input  logic [WIDTH-1:0]  ShiftIn,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [WIDTH-1:0]  Shifted,
  output logic              Sticky,
  output logic              Busy
);

  localparam logic [SHIFTW-1:0] WIDTH_W = SHIFTW'(WIDTH);
  localparam logic [SHIFTW-1:0] STEP_W  = SHIFTW'(STEP);
`ifdef RSHIFT_FASTZERO_EN
  localparam logic FASTZERO = 1'b1;
`else
  localparam logic FASTZERO = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   data_r;
  logic               sticky_r;
  logic [SHIFTW-1:0]  rem_r;

  logic [SHIFTW-1:0]  k_s;
  logic [WIDTH-1:0]   mask_s;
  logic [WIDTH-1:0]   data_shift_s;
  logic               sticky_shift_s;
  logic [SHIFTW-1:0]  rem_next_s;
  logic [SHIFTW-1:0]  amt_sat_s;
  logic               fast_s;

  // Per-cycle step: the shifted-out mask depends only on this cycle's k.
  always_comb begin
    k_s            = (rem_r < STEP_W) ? rem_r : STEP_W;
    mask_s         = ~({WIDTH{1'b1}} << k_s);
    data_shift_s   = data_r >> k_s;
    sticky_shift_s = sticky_r | (|(data_r & mask_s));
    rem_next_s     = rem_r - k_s;
    amt_sat_s      = (ShiftAmt >= WIDTH_W) ? WIDTH_W : ShiftAmt;
    fast_s         = FASTZERO & (ShiftAmt >= WIDTH_W);
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      data_r   <= {WIDTH{1'b0}};
      sticky_r <= 1'b0;
      rem_r    <= {SHIFTW{1'b0}};
      InReady  <= 1'b1;
      OutValid <= 1'b0;
      Busy     <= 1'b0;
    end else if (Flush) begin
      // Datapath registers are kept; they are don't-care while OutValid is low.
      state_r  <= IDLE;
      InReady  <= 1'b1;
      OutValid <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (InValid && InReady) begin
            InReady <= 1'b0;
            Busy    <= 1'b1;
            if (fast_s) begin
              data_r   <= {WIDTH{1'b0}};
              sticky_r <= |ShiftIn;
              rem_r    <= {SHIFTW{1'b0}};
              state_r  <= DONE;
              OutValid <= 1'b1;
            end else begin
              data_r   <= ShiftIn;
              sticky_r <= 1'b0;
              rem_r    <= amt_sat_s;
              if (amt_sat_s == {SHIFTW{1'b0}}) begin
                state_r  <= DONE;
                OutValid <= 1'b1;
              end else begin
                state_r <= SHIFT;
              end
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          data_r   <= data_shift_s;
          sticky_r <= sticky_shift_s;
          rem_r    <= rem_next_s;
          if (rem_next_s == {SHIFTW{1'b0}}) begin
            state_r  <= DONE;
            OutValid <= 1'b1;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (OutReady) begin
            state_r  <= IDLE;
            OutValid <= 1'b0;
            InReady  <= 1'b1;
            Busy     <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r  <= IDLE;
          InReady  <= 1'b1;
          OutValid <= 1'b0;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

  assign Shifted = data_r;
  assign Sticky  = sticky_r;

endmodule

// File: tb/tb_openhw_align_rshift.sv
// Scoreboard bench for openhw_align_rshift (WIDTH=64, STEP=8); latency
// expectations follow RSHIFT_FASTZERO_EN when it is defined.
module tb_openhw_align_rshift;

  logic        clk = 1'b0;
  logic        reset;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [6:0]  ShiftAmt;
  logic [63:0] ShiftIn;
  logic        OutValid;
  logic        OutReady;
  logic [63:0] Shifted;
  logic        Sticky;
  logic        Busy;

  typedef struct {
    logic [63:0] data;
    logic        sticky;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  openhw_align_rshift #(.WIDTH(64), .SHIFTW(7), .STEP(8)) dut (
    .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid),
    .InReady(InReady), .ShiftAmt(ShiftAmt), .ShiftIn(ShiftIn),
    .OutValid(OutValid), .OutReady(OutReady), .Shifted(Shifted),
    .Sticky(Sticky), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: shift into a wide window so every shifted-out bit is kept.
  task automatic push_expected(input logic [63:0] din, input logic [6:0] amt);
    exp_t        e;
    logic [191:0] ext;
    int          eff;
    ext      = {din, 128'd0} >> amt;
    e.data   = ext[191:128];
    e.sticky = |ext[127:0];
    eff      = (amt >= 7'd64) ? 64 : int'(amt);
    e.lat    = 1 + (eff + 7) / 8;
`ifdef RSHIFT_FASTZERO_EN
    if (amt >= 7'd64) e.lat = 1;
`endif
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!InReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!InReady) check_val("in_ready_timeout", 64'(InReady), 64'd1);
  endtask

  task automatic run_op(input logic [63:0] din, input logic [6:0] amt,
                        input int stall, input bit pulse);
    int   cyc;
    exp_t e;
    push_expected(din, amt);
    wait_ready();
    InValid  = 1'b1;
    ShiftIn  = din;
    ShiftAmt = amt;
    @(negedge clk);
    InValid  = 1'b0;
    ShiftIn  = ~din;
    ShiftAmt = 7'd3;
    cyc = 1;
    while (!OutValid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!OutValid || sb.size() == 0) begin
      check_val("out_valid_timeout", 64'(OutValid), 64'd1);
      return;
    end
    e = sb.pop_front();
    check_val("latency", 64'(cyc), 64'(e.lat));
    check_val("shifted", Shifted, e.data);
    check_val("sticky", 64'(Sticky), 64'(e.sticky));
    for (int s = 0; s < stall; s++) begin
      if (pulse) begin
        InValid  = 1'b1;
        ShiftIn  = 64'hDEAD_BEEF_0000_FFFF;
        ShiftAmt = 7'd1;
      end
      @(negedge clk);
      check_val("hold_valid", 64'(OutValid), 64'd1);
      check_val("hold_inready", 64'(InReady), 64'd0);
      check_val("hold_shifted", Shifted, e.data);
      check_val("hold_sticky", 64'(Sticky), 64'(e.sticky));
    end
    InValid  = 1'b0;
    OutReady = 1'b1;
    @(negedge clk);
    OutReady = 1'b0;
    check_val("handoff_valid", 64'(OutValid), 64'd0);
    check_val("handoff_inready", 64'(InReady), 64'd1);
    check_val("handoff_busy", 64'(Busy), 64'd0);
  endtask

  // Accept a 40-bit shift and return at the start of its second SHIFT cycle.
  task automatic start_long();
    wait_ready();
    InValid  = 1'b1;
    ShiftIn  = 64'hA5A5_A5A5_A5A5_A5A5;
    ShiftAmt = 7'd40;
    @(negedge clk);
    InValid = 1'b0;
    check_val("long_busy", 64'(Busy), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    Flush    = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b0;
    ShiftAmt = 7'd0;
    ShiftIn  = 64'd0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_inready", 64'(InReady), 64'd1);
    check_val("rst_outvalid", 64'(OutValid), 64'd0);
    check_val("rst_busy", 64'(Busy), 64'd0);
    check_val("rst_shifted", Shifted, 64'd0);
    check_val("rst_sticky", 64'(Sticky), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(64'h0000_0000_0000_1234, 7'd0, 0, 1'b0);
    run_op(64'h8000_0000_0000_0001, 7'd4, 0, 1'b0);
    run_op(64'hFFFF_0000_0000_0000, 7'd17, 1, 1'b0);
    run_op(64'h0000_0000_0000_0001, 7'd100, 0, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 0, 1'b0);
    run_op(64'h8000_0000_0000_0000, 7'd63, 0, 1'b0);
    run_op(64'h0123_4567_89AB_CDEF, 7'd8, 3, 1'b1);

    // Flush in the second SHIFT cycle.
    start_long();
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    check_val("flush_inready", 64'(InReady), 64'd1);
    check_val("flush_outvalid", 64'(OutValid), 64'd0);
    check_val("flush_busy", 64'(Busy), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("flush_quiet", 64'(OutValid), 64'd0);
    end
    run_op(64'hF0F0_0000_0000_0F0F, 7'd40, 0, 1'b0);

    // Async reset in the second SHIFT cycle takes effect without a clock edge.
    start_long();
    #1 reset = 1'b1;
    #1;
    check_val("areset_inready", 64'(InReady), 64'd1);
    check_val("areset_outvalid", 64'(OutValid), 64'd0);
    check_val("areset_busy", 64'(Busy), 64'd0);
    check_val("areset_shifted", Shifted, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(64'h0000_0000_FFFF_0000, 7'd20, 0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      run_op({$urandom, $urandom}, 7'($urandom_range(0, 127)),
             int'($urandom_range(0, 2)), 1'b0);
    end

    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/openhw_align_rshift.md
Name: openhw_align_rshift

Overview:
- Multi-cycle sticky-collecting right shifter; the counterpart of the FPU's left normalization shifter.
- Used for FMA addend alignment and for fp->fp denormalization of subnormal or underflowed results.
- Shifts an operand right by a requested amount, at most STEP bits per cycle, and ORs every bit shifted out into a sticky flag for rounding.
- Valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
- WIDTH, 64, operand/result width in bits.
- SHIFTW, 7, width of the shift-amount field; must satisfy 2^SHIFTW > WIDTH.
- STEP, 8, maximum bits shifted right per cycle; power of two, 1 <= STEP <= WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Flush  input  1  synchronous abort of the in-flight operation.
- InValid  input  1  request valid.
- InReady  output  1  block can accept a request (high only in IDLE).
- ShiftAmt  input  SHIFTW  right-shift amount, unsigned.
- ShiftIn  input  WIDTH  operand.
- OutValid  output  1  result valid.
- OutReady  input  1  consumer accepts result.
- Shifted  output  WIDTH  ShiftIn >> ShiftAmt (logical right shift).
- Sticky  output  1  OR of all bits shifted out.
- Busy  output  1  high in SHIFT or DONE.

Behaviour:
- All outputs are registered. Reset values: state=IDLE, InReady=1, OutValid=0, Busy=0, Shifted=0, Sticky=0.
- IDLE:
  - When InValid&InReady, capture ShiftIn into the data register and clear sticky.
  - Remaining = min(ShiftAmt, WIDTH); amounts >= WIDTH saturate to WIDTH.
  - If Remaining==0, go to DONE; otherwise go to SHIFT.
- SHIFT, each cycle:
  - k = min(Remaining, STEP).
  - data <= data >> k; sticky <= sticky | (OR of the low k bits of data); Remaining <= Remaining - k.
  - Go to DONE when Remaining-k == 0.
- Cycles in SHIFT = ceil(min(ShiftAmt,WIDTH)/STEP).
- Timing: accept in cycle 0; OutValid rises in cycle 1 + cycles in SHIFT.
- DONE:
  - OutValid=1; Shifted and Sticky are driven from the registers and held stable while OutReady=0.
  - On OutReady, go to IDLE; OutValid falls and InReady rises in the next cycle.
  - No back-to-back acceptance in the handoff cycle.
- InValid is ignored outside IDLE; ShiftAmt/ShiftIn are sampled only at the accept edge.
- Flush:
  - In any state, next state is IDLE, OutValid=0, InReady=1; in-flight data is discarded.
  - Flush has priority over the accept and over the OutReady handshake.
  - Shifted/Sticky retain their last values; they are don't-care when OutValid=0.
- reset asserted mid-operation: immediate return to reset values, independent of clk.
- Width rules:
  - Remaining needs SHIFTW bits.
  - A full-width shift yields Shifted=0 and Sticky=|ShiftIn.
  - The per-cycle sticky mask is built from k alone, never from ShiftAmt.

Optional Feature:
- Macro: RSHIFT_FASTZERO_EN.
- Defined: an accept with ShiftAmt >= WIDTH bypasses SHIFT. The block goes straight to DONE with Shifted=0 and Sticky=|ShiftIn, so OutValid rises in cycle 1.
- Not defined: the amount saturates to WIDTH and iterates ceil(WIDTH/STEP) cycles with the same final result.
- Results are bit-identical either way; only latency differs.

Test Plan (WIDTH=64, STEP=8):
- ShiftIn=0x1234, ShiftAmt=0 -> OutValid in cycle 1, Shifted=0x1234, Sticky=0.
- ShiftIn=0x8000_0000_0000_0001, ShiftAmt=4 -> 1 SHIFT cycle; OutValid in cycle 2, Shifted=0x0800_0000_0000_0000, Sticky=1.
- ShiftIn=0xFFFF_0000_0000_0000, ShiftAmt=17 -> 3 SHIFT cycles (8,8,1); OutValid in cycle 4, Shifted=0x0000_7FFF_8000_0000, Sticky=0.
- ShiftIn=0x1, ShiftAmt=100 -> Shifted=0, Sticky=1; OutValid in cycle 9 without the macro, cycle 1 with RSHIFT_FASTZERO_EN.
- Result ready with OutReady=0 for 3 cycles, InValid pulsed -> Shifted/Sticky/OutValid stable, InReady=0, request ignored; OutReady=1 -> IDLE next cycle.
- Flush (or async reset) in the 2nd SHIFT cycle of ShiftAmt=40 -> IDLE next edge (reset: immediately), OutValid never asserted, InReady=1; a subsequent request completes correctly.
